// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI bus-cycle initiator and host-side models:
// bus-cycle phases, PPI register selects, control-word bits and phase helpers.
package ppi_pkg;

   // Bus-cycle phases, in the order one cycle walks through them.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RECOVER
   } ppi_state_t;

   // PPI register select values driven on A[1:0].
   localparam logic [1:0] PPI_PORT_A = 2'b00;
   localparam logic [1:0] PPI_PORT_B = 2'b01;
   localparam logic [1:0] PPI_PORT_C = 2'b10;
   localparam logic [1:0] PPI_CTRL   = 2'b11;

   // Control-word layout: bit 7 set selects mode-set, clear selects bit set/reset.
   localparam int         CW_MODE_SET_BIT = 7;
   localparam logic [7:0] CW_MODE_SET     = 8'h80;

   // Level seen on D when nobody drives it (pulled-up bus).
   localparam logic [7:0] BUS_IDLE = 8'hFF;

   // Phase lengths must fit the 4-bit phase counter and last at least one cycle.
   function automatic logic phase_len_ok(input int n);
      return (n >= 1) && (n <= 15);
   endfunction

   // Counter load value for a phase lasting n cycles.
   function automatic logic [3:0] phase_load(input int n);
      return 4'(n - 1);
   endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// Request/response channel plus the 8255-style PPI processor bus.
// The shared data bus D is resolved here from the master's and the PPI's
// output enables; with neither enabled the bus floats to its pulled-up level.
interface ppi_bus_master_if;
   import ppi_pkg::*;

   // Host request / response channel
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   // PPI processor bus
   logic       CS_n;
   logic       RD_n;
   logic       WR_n;
   logic [1:0] A;
   logic [7:0] D;

   // Per-side drivers of D
   logic [7:0] d_out;     // master write data
   logic       d_oe;      // master drives D
   logic [7:0] ppi_dout;  // PPI read data
   logic       ppi_oe;    // PPI drives D

   // Master has priority; it never enables during reads, so the two never overlap.
   assign D = d_oe ? d_out : (ppi_oe ? ppi_dout : BUS_IDLE);

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, D,
      output req_ready, rsp_valid, rsp_rdata,
      output CS_n, RD_n, WR_n, A, d_out, d_oe
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, ppi_dout, ppi_oe,
      input  req_ready, rsp_valid, rsp_rdata,
      input  CS_n, RD_n, WR_n, A, D, d_oe
   );

endinterface

// File: rtl/ppi_cycle_timer.sv
// 4-bit loadable down-counter timing one bus-cycle phase. Loaded with N-1 on
// phase entry; done is high while the count sits at zero (last phase cycle).
module ppi_cycle_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       done
);

   logic [3:0] count;

   // Load on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Converts one valid/ready host request into one fully timed PPI read or
// write strobe cycle: SETUP -> STROBE -> HOLD -> RECOVER -> IDLE.
// Every bus output comes straight from a flop so strobes cannot glitch.
module ppi_bus_master
   import ppi_pkg::*;
#(
   parameter int SETUP_CYC    = 1,
   parameter int STROBE_CYC   = 2,
   parameter int HOLD_CYC     = 1,
   parameter int RECOVERY_CYC = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   ppi_bus_master_if.master bus
);

   // Reject phase lengths the 4-bit phase counter cannot represent.
   if (!phase_len_ok(SETUP_CYC) || !phase_len_ok(STROBE_CYC) ||
       !phase_len_ok(HOLD_CYC)  || !phase_len_ok(RECOVERY_CYC)) begin : g_cfg_error
      $error("ppi_bus_master: SETUP/STROBE/HOLD/RECOVERY_CYC must each be in 1..15");
   end

   ppi_state_t state;
   logic       is_write;
   logic       cs_n_q;
   logic       rd_n_q;
   logic       wr_n_q;
   logic [1:0] a_q;
   logic [7:0] d_q;
   logic       d_oe_q;
   logic       ready_q;
   logic       rsp_valid_q;
   logic [7:0] rdata_q;

   logic       accept;
   logic       phase_done;
   logic       tmr_load;
   logic [3:0] tmr_val;

   // ready_q is high exactly while idle, so this is the IDLE-state handshake.
   assign accept = ready_q && bus.req_valid;

   ppi_cycle_timer u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (phase_done)
   );

   // Load the phase timer with the length of the phase being entered.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      tmr_load = 1'b0;
      tmr_val  = 4'd0;
      case (state)
         IDLE: begin
            tmr_load = accept;
            tmr_val  = phase_load(SETUP_CYC);
         end
         SETUP: begin
            tmr_load = phase_done;
            tmr_val  = phase_load(STROBE_CYC);
         end
         STROBE: begin
            tmr_load = phase_done;
            tmr_val  = phase_load(HOLD_CYC);
         end
         HOLD: begin
            tmr_load = phase_done;
            tmr_val  = phase_load(RECOVERY_CYC);
         end
         default: begin
            tmr_load = 1'b0;
            tmr_val  = 4'd0;
         end
      endcase
   end

   // Phase sequencing with registered bus, handshake and response outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         is_write    <= 1'b0;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         a_q         <= PPI_PORT_A;
         d_q         <= 8'h00;
         d_oe_q      <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 8'h00;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= SETUP;
                  is_write <= bus.req_write;
                  a_q      <= bus.req_addr;
                  d_q      <= bus.req_wdata;
                  d_oe_q   <= bus.req_write;
                  cs_n_q   <= 1'b0;
                  ready_q  <= 1'b0;
               end
            end
            SETUP: begin
               if (phase_done) begin
                  state  <= STROBE;
                  rd_n_q <= is_write;
                  wr_n_q <= !is_write;
               end
            end
            STROBE: begin
               if (phase_done) begin
                  state   <= HOLD;
                  rd_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  // Sampled on the edge that raises RD_n, so the PPI still drives D.
                  rdata_q <= is_write ? 8'h00 : bus.D;
               end
            end
            HOLD: begin
               if (phase_done) begin
                  state       <= RECOVER;
                  cs_n_q      <= 1'b1;
                  d_oe_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
               end
            end
            RECOVER: begin
               if (phase_done) begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cs_n_q  <= 1'b1;
               rd_n_q  <= 1'b1;
               wr_n_q  <= 1'b1;
               d_oe_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.CS_n      = cs_n_q;
   assign bus.RD_n      = rd_n_q;
   assign bus.WR_n      = wr_n_q;
   assign bus.A         = a_q;
   assign bus.d_out     = d_q;
   assign bus.d_oe      = d_oe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: one DUT at default timing, one with
// SETUP=3/STROBE=4/HOLD=2/RECOVERY=2. A tiny PPI model drives D while its
// CS_n and RD_n are both low. Expected waveforms come from the phase lengths.
module tb_ppi_bus_master;
   import ppi_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sel_par = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [1:0] req_addr = 2'b00;
   logic [7:0] req_wdata = 8'h00;
   logic [7:0] ppi_data = 8'h5A;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ppi_bus_master_if bd ();
   ppi_bus_master_if bp ();

   ppi_bus_master dut_def (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bd.master)
   );

   ppi_bus_master #(
      .SETUP_CYC    (3),
      .STROBE_CYC   (4),
      .HOLD_CYC     (2),
      .RECOVERY_CYC (2)
   ) dut_par (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bp.master)
   );

   // Host side: shared request fields, valid steered to the selected DUT.
   assign bd.req_valid = req_valid && !sel_par;
   assign bd.req_write = req_write;
   assign bd.req_addr  = req_addr;
   assign bd.req_wdata = req_wdata;
   assign bp.req_valid = req_valid && sel_par;
   assign bp.req_write = req_write;
   assign bp.req_addr  = req_addr;
   assign bp.req_wdata = req_wdata;

   // PPI model: drives read data while selected and read-strobed.
   assign bd.ppi_oe   = !bd.CS_n && !bd.RD_n;
   assign bd.ppi_dout = ppi_data;
   assign bp.ppi_oe   = !bp.CS_n && !bp.RD_n;
   assign bp.ppi_dout = ppi_data;

   // Observed outputs of the selected DUT.
   logic       o_cs, o_rd, o_wr, o_oe, o_ready, o_rsp;
   logic [1:0] o_a;
   logic [7:0] o_d, o_rdata;
   assign o_cs    = sel_par ? bp.CS_n      : bd.CS_n;
   assign o_rd    = sel_par ? bp.RD_n      : bd.RD_n;
   assign o_wr    = sel_par ? bp.WR_n      : bd.WR_n;
   assign o_oe    = sel_par ? bp.d_oe      : bd.d_oe;
   assign o_ready = sel_par ? bp.req_ready : bd.req_ready;
   assign o_rsp   = sel_par ? bp.rsp_valid : bd.rsp_valid;
   assign o_a     = sel_par ? bp.A         : bd.A;
   assign o_d     = sel_par ? bp.D         : bd.D;
   assign o_rdata = sel_par ? bp.rsp_rdata : bd.rsp_rdata;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current (idle) cycle and take the accept edge.
   task automatic start(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                        input logic keep_valid);
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      req_valid = 1'b1;
      step();
      if (!keep_valid) req_valid = 1'b0;
   endtask

   // Check every cycle of one bus cycle, from the first SETUP cycle through the
   // following IDLE cycle. Ends in that IDLE cycle, before its closing edge.
   task automatic follow(input string tag, input logic wr, input logic [1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata,
                         input int s, input int t, input int h, input int r,
                         input logic poke);
      int  last;
      bit  in_cs, in_stb, first_rec, idle;
      last = s + t + h + r + 1;
      for (int c = 1; c <= last; c++) begin
         in_cs     = (c <= s + t + h);
         in_stb    = (c > s) && (c <= s + t);
         first_rec = (c == s + t + h + 1);
         idle      = (c == last);
         check($sformatf("%s c%0d CS_n", tag, c), {7'd0, o_cs}, {7'd0, !in_cs});
         check($sformatf("%s c%0d RD_n", tag, c), {7'd0, o_rd}, {7'd0, !(in_stb && !wr)});
         check($sformatf("%s c%0d WR_n", tag, c), {7'd0, o_wr}, {7'd0, !(in_stb && wr)});
         check($sformatf("%s c%0d d_oe", tag, c), {7'd0, o_oe}, {7'd0, in_cs && wr});
         check($sformatf("%s c%0d rsp_valid", tag, c), {7'd0, o_rsp}, {7'd0, first_rec});
         check($sformatf("%s c%0d req_ready", tag, c), {7'd0, o_ready}, {7'd0, idle});
         if (in_cs) check($sformatf("%s c%0d A", tag, c), {6'd0, o_a}, {6'd0, addr});
         if (in_cs && wr) check($sformatf("%s c%0d D", tag, c), o_d, wdata);
         if (first_rec || idle) check($sformatf("%s c%0d rsp_rdata", tag, c), o_rdata, rdata);
         if (poke && c == s + 1) begin
            req_valid = 1'b1;
            req_write = !wr;
            req_addr  = ~addr;
            req_wdata = 8'hFF;
         end
         if (poke && c == s + 2) req_valid = 1'b0;
         if (c < last) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values while reset is held.
      #12;
      check("rst CS_n", {7'd0, o_cs}, 8'd1);
      check("rst RD_n", {7'd0, o_rd}, 8'd1);
      check("rst WR_n", {7'd0, o_wr}, 8'd1);
      check("rst d_oe", {7'd0, o_oe}, 8'd0);
      check("rst A", {6'd0, o_a}, 8'd0);
      check("rst rsp_valid", {7'd0, o_rsp}, 8'd0);
      check("rst rsp_rdata", o_rdata, 8'h00);
      #11 reset_n = 1'b1;
      step();
      check("post-rst req_ready", {7'd0, o_ready}, 8'd1);
      check("post-rst CS_n", {7'd0, o_cs}, 8'd1);
      sel_par = 1'b1;
      #1;
      check("par post-rst req_ready", {7'd0, o_ready}, 8'd1);
      check("par post-rst CS_n", {7'd0, o_cs}, 8'd1);
      sel_par = 1'b0;

      // Mode-set write to the control register.
      start(1'b1, PPI_CTRL, CW_MODE_SET, 1'b0);
      follow("wr", 1'b1, PPI_CTRL, CW_MODE_SET, 8'h00, 1, 2, 1, 1, 1'b0);

      // Read port A, PPI returns 5A.
      ppi_data = 8'h5A;
      start(1'b0, PPI_PORT_A, 8'h00, 1'b0);
      follow("rd", 1'b0, PPI_PORT_A, 8'h00, 8'h5A, 1, 2, 1, 1, 1'b0);

      // Back-to-back writes with req_valid held high.
      start(1'b1, PPI_PORT_B, 8'h11, 1'b1);
      req_addr  = PPI_PORT_C;
      req_wdata = 8'h22;
      follow("b2b1", 1'b1, PPI_PORT_B, 8'h11, 8'h00, 1, 2, 1, 1, 1'b0);
      step();
      req_valid = 1'b0;
      follow("b2b2", 1'b1, PPI_PORT_C, 8'h22, 8'h00, 1, 2, 1, 1, 1'b0);

      // Request pulsed during STROBE must be ignored.
      start(1'b1, PPI_PORT_A, 8'hC3, 1'b0);
      follow("busy", 1'b1, PPI_PORT_A, 8'hC3, 8'h00, 1, 2, 1, 1, 1'b1);
      step();
      check("busy after CS_n", {7'd0, o_cs}, 8'd1);
      check("busy after req_ready", {7'd0, o_ready}, 8'd1);

      // Non-default timing: write then read.
      sel_par = 1'b1;
      #1;
      start(1'b1, PPI_PORT_B, 8'hA5, 1'b0);
      follow("par wr", 1'b1, PPI_PORT_B, 8'hA5, 8'h00, 3, 4, 2, 2, 1'b0);
      ppi_data = 8'h3C;
      start(1'b0, PPI_PORT_C, 8'h00, 1'b0);
      follow("par rd", 1'b0, PPI_PORT_C, 8'h00, 8'h3C, 3, 4, 2, 2, 1'b0);
      sel_par = 1'b0;
      #1;

      // Reset asserted in the second STROBE cycle of a write.
      start(1'b1, PPI_PORT_A, 8'h99, 1'b0);
      step();
      step();
      check("mid WR_n before rst", {7'd0, o_wr}, 8'd0);
      #2 reset_n = 1'b0;
      #1;
      check("mid rst CS_n", {7'd0, o_cs}, 8'd1);
      check("mid rst WR_n", {7'd0, o_wr}, 8'd1);
      check("mid rst d_oe", {7'd0, o_oe}, 8'd0);
      check("mid rst rsp_valid", {7'd0, o_rsp}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("in rst %0d rsp_valid", i), {7'd0, o_rsp}, 8'd0);
      end
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("after rst %0d req_ready", i), {7'd0, o_ready}, 8'd1);
         check($sformatf("after rst %0d rsp_valid", i), {7'd0, o_rsp}, 8'd0);
         check($sformatf("after rst %0d CS_n", i), {7'd0, o_cs}, 8'd1);
      end

      // A fresh read works normally after the mid-cycle reset.
      ppi_data = 8'hE7;
      start(1'b0, PPI_PORT_B, 8'h00, 1'b0);
      follow("rd2", 1'b0, PPI_PORT_B, 8'h00, 8'hE7, 1, 2, 1, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
